// File: rtl/cpu_pkg.sv
// Shared pipeline types and constants for the single-issue 32-bit core.
// Used by the fetch stage and by later stages that reuse the IF/ID layout.
package cpu_pkg;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES       = 32'd4;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  // 33-bit compare so a PC near the top of the address space cannot wrap past the limit.
  function automatic logic fetch_in_range(input logic [31:0] pc, input logic [32:0] limit);
    return (({1'b0, pc} + {1'b0, WORD_BYTES}) <= limit);
  endfunction

endpackage

// File: rtl/if_fetch_stage_ifid_reg.sv
// IF/ID style pipeline register with squash (bubble) and hold controls.
// Priority: rst > squash > hold > load; a squash keeps the pc/pc4 fields.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] BUBBLE_WORD = cpu_pkg::NOP_WORD
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  hold_i,
  input  logic  squash_i,
  input  logic  load_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t reg_q;
  ifid_t reg_d;

  // Next-value selection for the pipeline register.
  always_comb begin
    reg_d = reg_q;
    if (squash_i) begin
      reg_d.instr = BUBBLE_WORD;
      reg_d.valid = 1'b0;
    end else if (hold_i) begin
      reg_d = reg_q;
    end else if (load_i) begin
      reg_d = d_i;
    end else begin
      reg_d = reg_q;
    end
  end

  // Register state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q.instr <= BUBBLE_WORD;
      reg_q.pc    <= 32'h0000_0000;
      reg_q.pc4   <= 32'h0000_0000;
      reg_q.valid <= 1'b0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign q_o = reg_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction memory,
// and feeds the IF/ID register; handles stalls, redirects, range halts and misaligned targets.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = cpu_pkg::DEFAULT_RESET_PC,
  parameter int unsigned IMEM_BYTES = 512,
  parameter logic [31:0] NOP_WORD   = cpu_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BYTES);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  count_q, count_d;
  logic         squash_s, hold_s, load_s;
  logic         target_misaligned_s;
  ifid_t        capture_s;
  ifid_t        ifid_s;

  assign target_misaligned_s = (redirect_pc[1:0] != 2'b00);

  // Next-state, next-PC and IF/ID control decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    count_d    = count_q;
    squash_s   = 1'b0;
    hold_s     = 1'b0;
    load_s     = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          squash_s = 1'b1;
          if (target_misaligned_s) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (stall) begin
          hold_s = 1'b1;
        end else if (fetch_in_range(pc_q, IMEM_LIMIT)) begin
          load_s  = 1'b1;
          pc_d    = pc_q + WORD_BYTES;
          count_d = count_q + 32'd1;
        end else begin
          squash_s = 1'b1;
          state_d  = HALT;
        end
      end
      HALT: begin
        // Stall is ignored here; every cycle in HALT is a bubble, including the exit cycle.
        squash_s = 1'b1;
        if (redirect_valid) begin
          if (target_misaligned_s) begin
            misalign_d = 1'b1;
          end else begin
            pc_d    = redirect_pc;
            state_d = RUN;
          end
        end else begin
          state_d = HALT;
        end
      end
      default: begin
        squash_s = 1'b1;
        state_d  = HALT;
      end
    endcase
  end

  // Fetch-stage state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      count_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign capture_s.instr = imem_instr;
  assign capture_s.pc    = pc_q;
  assign capture_s.pc4   = pc_q + WORD_BYTES;
  assign capture_s.valid = 1'b1;

  ifid_reg #(
    .BUBBLE_WORD (NOP_WORD)
  ) u_ifid_reg (
    .clk      (clk),
    .rst      (rst),
    .hold_i   (hold_s),
    .squash_i (squash_s),
    .load_i   (load_s),
    .d_i      (capture_s),
    .q_o      (ifid_s)
  );

  assign imem_pc      = pc_q;
  assign ifid_instr   = ifid_s.instr;
  assign ifid_pc      = ifid_s.pc;
  assign ifid_pc4     = ifid_s.pc4;
  assign ifid_valid   = ifid_s.valid;
  assign halted       = (state_q == HALT);
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a driver pushes reference-model expectations
// per clock, and a monitor pops and compares them after each rising edge.
module tb_if_fetch_stage;

  localparam int unsigned IMEM = 16;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_pc, imem_instr;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc4, fetch_count;
  logic        ifid_valid, halted, misalign_err;

  logic [31:0] mem [16];

  typedef struct {
    logic [31:0] instr, pc, pc4, ipc, cnt;
    logic        valid, halt, mis;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_cnt;
  logic        m_valid, m_halt, m_mis;

  always #5 clk = ~clk;

  assign imem_instr = (imem_pc < 32'd64) ? mem[imem_pc[5:2]] : 32'hDEAD_BEEF;

  if_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (IMEM),
    .NOP_WORD   (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc4       (ifid_pc4),
    .ifid_valid     (ifid_valid),
    .halted         (halted),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // One clock of behaviour, stated directly from the stage's rules.
  task automatic model_step(input logic r, input logic s, input logic rv, input logic [31:0] rpc);
    if (r) begin
      m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_ipc4 = 32'h0;
      m_valid = 1'b0; m_halt = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
    end else if (rv) begin
      m_instr = NOP; m_valid = 1'b0;
      if (rpc % 4 != 0) begin
        m_mis = 1'b1; m_halt = 1'b1;
      end else begin
        m_pc = rpc; m_halt = 1'b0;
      end
    end else if (m_halt) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (s) begin
      // everything holds
    end else if (longint'(m_pc) + 4 <= longint'(IMEM)) begin
      m_instr = mem[m_pc / 4]; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
    end else begin
      m_instr = NOP; m_valid = 1'b0; m_halt = 1'b1;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] rpc);
    exp_t e;
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
    model_step(r, s, rv, rpc);
    e.instr = m_instr; e.pc = m_ipc; e.pc4 = m_ipc4; e.ipc = m_pc; e.cnt = m_cnt;
    e.valid = m_valid; e.halt = m_halt; e.mis = m_mis;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare the DUT against the oldest pending expectation after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ifid_instr",   ifid_instr,            e.instr);
      chk("ifid_pc",      ifid_pc,               e.pc);
      chk("ifid_pc4",     ifid_pc4,              e.pc4);
      chk("ifid_valid",   {31'd0, ifid_valid},   {31'd0, e.valid});
      chk("imem_pc",      imem_pc,               e.ipc);
      chk("halted",       {31'd0, halted},       {31'd0, e.halt});
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
      chk("fetch_count",  fetch_count,           e.cnt);
    end
  end

  initial begin
    logic [31:0] rpc;
    int          sel;
    mem[0] = 32'h0043_0820;
    mem[1] = 32'h0043_0822;
    mem[2] = 32'h0062_0820;
    for (int i = 3; i < 16; i++) mem[i] = $urandom;

    // Reset, then three captures
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);

    // Stall held two cycles after the first capture
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);

    // Redirect wins over a same-cycle stall
    cyc(1'b0, 1'b1, 1'b1, 32'd8);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);

    // Misaligned redirect halts; stall ignored in HALT; aligned redirect resumes
    cyc(1'b0, 1'b0, 1'b1, 32'd6);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'd0);

    // Free run to the end of memory and halt
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);

    // Reset with a same-cycle redirect, then capture from address 0
    cyc(1'b1, 1'b0, 1'b1, 32'd8);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);

    // Randomised traffic including top-of-address-space targets
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       rpc = {26'd0, 4'($urandom_range(0, 7)), 2'b00};
      else if (sel < 8)  rpc = 32'($urandom_range(0, 31));
      else if (sel == 8) rpc = 32'hFFFF_FFFC;
      else               rpc = 32'hFFFF_FFF8;
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 6) == 0), rpc);
    end

    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage for the single-issue 32-bit pipeline.
- Owns the program counter and drives it to the byte-addressed, big-endian, combinational instruction memory.
- Registers the returned 32-bit word into the IF/ID pipeline register for decode.
- Handles hazard-unit stalls, branch/jump redirects, out-of-range fetch halting and misaligned-target errors.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
IMEM_BYTES, 512, instruction memory size in bytes; a fetch is legal when pc <= IMEM_BYTES-4.
NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID as a bubble.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
stall  input  1  hazard unit: hold PC and IF/ID contents
redirect_valid  input  1  taken branch/jump from EX: load redirect_pc, squash IF/ID
redirect_pc  input  32  redirect target byte address
imem_pc  output  32  byte address to instruction memory; equals the PC register
imem_instr  input  32  instruction word returned combinationally for imem_pc
ifid_instr  output  32  registered instruction to decode
ifid_pc  output  32  address of ifid_instr
ifid_pc4  output  32  ifid_pc + 4 (link value / branch base)
ifid_valid  output  1  ifid_instr is a real instruction (0 = bubble)
halted  output  1  stage is in HALT
misalign_err  output  1  sticky: a redirect target had pc[1:0] != 0
fetch_count  output  32  number of instructions accepted into IF/ID since reset

Behaviour:
- Reset, on any edge with rst=1:
  - pc=RESET_PC; ifid_instr=NOP_WORD; ifid_pc=0; ifid_pc4=0.
  - ifid_valid=0; state=RUN; misalign_err=0; fetch_count=0.
  - Instruction memory is initialised while rst is high; the fetch stage issues no capture during reset.
- Latency: imem_pc=pc combinationally. The word at pc is captured into IF/ID at the next edge, so decode sees the instruction one cycle after its PC is presented.
- States: RUN, HALT. Per-edge priority (rst excluded): redirect_valid > stall > normal.
- RUN, redirect_valid=1:
  - IF/ID becomes a bubble: ifid_instr=NOP_WORD, ifid_valid=0; ifid_pc and ifid_pc4 hold.
  - If redirect_pc[1:0]!=0: misalign_err=1, pc holds, go to HALT.
  - Otherwise pc=redirect_pc and stay in RUN. This holds even if stall=1 the same cycle; redirect wins.
- RUN, stall=1, no redirect: pc, all ifid_* outputs and fetch_count hold.
- RUN, normal, pc <= IMEM_BYTES-4:
  - ifid_instr=imem_instr; ifid_pc=pc; ifid_pc4=pc+4; ifid_valid=1.
  - pc=pc+4; fetch_count+=1.
- RUN, normal, pc > IMEM_BYTES-4: no capture; ifid_valid=0, ifid_instr=NOP_WORD; pc holds; go to HALT.
- HALT:
  - halted=1; pc holds; ifid_valid=0; stall is ignored.
  - An aligned redirect_valid loads pc=redirect_pc and returns to RUN, still emitting a bubble that cycle.
  - A misaligned redirect sets misalign_err and stays in HALT. Only rst clears misalign_err.
- Arithmetic: all PC sums are 32-bit modulo 2^32; pc+4 wrap is not special-cased because the range check halts first. fetch_count wraps at 2^32.
- Range check uses a 33-bit compare so pc near 32'hFFFF_FFFC never falsely passes.
- Reset mid-operation: synchronous reset overrides stall and redirect on the same edge; the first post-reset capture fetches RESET_PC.
- halted is a registered state decode; there is no combinational path from stall or redirect to any ifid_* output.

Decomposition:
- Shared package `cpu_pkg`:
  - NOP_WORD, DEFAULT_RESET_PC, WORD_BYTES=4.
  - fetch_state_t enum {RUN, HALT}.
  - ifid_t struct {instr, pc, pc4, valid}, reused by the decode stage.
- One sub-module, `ifid_reg`: the IF/ID pipeline register with hold (stall) and squash (bubble) controls, reusable for the ID/EX style registers.
- PC/next-PC logic and the FSM stay in if_fetch_stage.

Test Plan:
1. Memory words {00430820, 00430822, 00620820} at bytes 0..11; rst for 2 cycles, then release -> edges 1/2/3 give ifid_instr=00430820/00430822/00620820, ifid_pc=0/4/8, ifid_valid=1, fetch_count=3.
2. Stall held 2 cycles after the first capture -> ifid_instr stays 00430820 and imem_pc stays 4 for both cycles; next edge gives 00430822.
3. Redirect_valid=1 with redirect_pc=8 and stall=1 the same cycle -> next edge ifid_valid=0, imem_pc=8; following edge ifid_instr=00620820, ifid_pc=8.
4. Redirect_pc=6 -> misalign_err=1, halted=1, ifid_valid=0 thereafter; a later redirect to 0 resumes fetch while misalign_err stays 1.
5. IMEM_BYTES=16, free run -> captures at pc 0,4,8,12; on the edge with pc=16, halted=1 and ifid_valid=0; fetch_count=4 and holds.
6. rst asserted for 1 cycle mid-run with redirect_valid=1 the same cycle -> pc=0, ifid_valid=0, fetch_count=0, misalign_err=0; the first edge after release captures the word at 0.
